// File: rtl/playfield_store.sv
// -----------------------------------------------------------------------------
// playfield_store
//   Board occupancy memory for the falling-block game. It sits downstream of
//   the game sequencer and executes its commands: OR the active piece into the
//   board, delete a completed row, and test a freshly spawned piece for
//   collision. It reports the full-row vector and a sticky game-over code back
//   to the sequencer. It also provides a registered read port for the video
//   renderer and counts cleared lines.
//
// Ports
//   clk            in   1        system clock
//   reset          in   1        synchronous, active-high; wins over cmd
//   cmd            in   3        sequencer command (chk/down/write/shift/add/lr)
//   shift_row      in   ROWS     one-hot row to delete, used when cmd = shift
//   piece_mask     in   16       active piece 4x4, bit 4*r+c = cell (r,c)
//   piece_x        in   5        board column of mask column 0
//   piece_y        in   5        board row of mask row 0
//   full_rows      out  ROWS     bit r set when every cell of row r is occupied
//   game_over      out  2        00 run, 01 write overlap, 10 spawn blocked
//   lines_cleared  out  LINES_W  rows deleted since reset (wraps)
//   rd_row         in   5        renderer row address
//   rd_data        out  COLS     occupancy of rd_row, one cycle later
// -----------------------------------------------------------------------------
module playfield_store #(
    parameter int ROWS    = 22,
    parameter int COLS    = 10,
    parameter int LINES_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         cmd,
    input  logic [ROWS-1:0]    shift_row,
    input  logic [15:0]        piece_mask,
    input  logic [4:0]         piece_x,
    input  logic [4:0]         piece_y,
    output logic [ROWS-1:0]    full_rows,
    output logic [1:0]         game_over,
    output logic [LINES_W-1:0] lines_cleared,
    input  logic [4:0]         rd_row,
    output logic [COLS-1:0]    rd_data
);

    localparam int ROW_W = $clog2(ROWS);

    typedef enum logic [2:0] {
        CMD_CHK   = 3'b000,
        CMD_DOWN  = 3'b001,
        CMD_WRITE = 3'b010,
        CMD_SHIFT = 3'b011,
        CMD_ADD   = 3'b100,
        CMD_LR    = 3'b111
    } cmd_e;

    typedef enum logic [1:0] {
        GO_RUN     = 2'b00,
        GO_OVERLAP = 2'b01,
        GO_BLOCKED = 2'b10
    } go_e;

    // Board storage: bit c of a row word is column c; row 0 is the top row.
    logic [COLS-1:0]    board_q [ROWS];
    logic [COLS-1:0]    board_d [ROWS];
    go_e                game_over_q, game_over_d;
    logic [LINES_W-1:0] lines_q, lines_d;
    logic [COLS-1:0]    rd_data_q, rd_data_d;

    // Piece footprint projected onto the board, already clipped to the board.
    logic [COLS-1:0]    footprint [ROWS];
    logic               overlap;

    // Bottom-most requested row of a shift command.
    logic               shift_hit;
    logic [ROW_W-1:0]   shift_k;

    // -------------------------------------------------------------------------
    // Footprint: each board cell looks back at the mask cell that would cover
    // it. Cells the piece would place outside the board simply have no board
    // cell looking at them, so clipping falls out for free.
    // -------------------------------------------------------------------------
    always_comb begin
        int dr;
        int dc;
        logic [3:0] mask_idx;
        // NOTE: every variable gets a default before any conditional
        // assignment, so no path leaves it holding a stale value (no latch).
        dr       = 0;
        dc       = 0;
        mask_idx = '0;
        for (int i = 0; i < ROWS; i++) begin
            footprint[i] = '0;
            for (int j = 0; j < COLS; j++) begin
                dr = i - int'(piece_y);
                dc = j - int'(piece_x);
                if (dr >= 0 && dr < 4 && dc >= 0 && dc < 4) begin
                    mask_idx        = 4'(dr * 4 + dc);
                    footprint[i][j] = piece_mask[mask_idx];
                end
            end
        end
    end

    always_comb begin
        overlap = 1'b0;
        for (int i = 0; i < ROWS; i++) begin
            if (|(footprint[i] & board_q[i])) begin
                overlap = 1'b1;
            end
        end
    end

    // Highest set index wins, so extra bits above the bottom-most are ignored.
    always_comb begin
        shift_hit = 1'b0;
        shift_k   = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (shift_row[i]) begin
                shift_hit = 1'b1;
                shift_k   = ROW_W'(i);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Command execution
    // -------------------------------------------------------------------------
    always_comb begin
        board_d     = board_q;
        game_over_d = game_over_q;
        lines_d     = lines_q;

        case (cmd)
            CMD_WRITE: begin
                // The OR happens even when it overlaps; the sequencer decides
                // what to do with the game-over report.
                for (int i = 0; i < ROWS; i++) begin
                    board_d[i] = board_q[i] | footprint[i];
                end
                if (overlap && game_over_q == GO_RUN) begin
                    game_over_d = GO_OVERLAP;
                end
            end
            CMD_SHIFT: begin
                if (shift_hit) begin
                    // Rows 0..k move down by one; row 0 refills empty.
                    board_d[0] = '0;
                    for (int i = 1; i < ROWS; i++) begin
                        if (ROW_W'(i) <= shift_k) begin
                            board_d[i] = board_q[i-1];
                        end
                    end
                    lines_d = lines_q + LINES_W'(1);
                end
            end
            CMD_ADD: begin
                if (overlap && game_over_q == GO_RUN) begin
                    game_over_d = GO_BLOCKED;
                end
            end
            default: ;
        endcase
    end

    // Renderer port samples the board before this edge's update (read-old).
    always_comb begin
        rd_data_d = '0;
        if (int'(rd_row) < ROWS) begin
            rd_data_d = board_q[rd_row];
        end
    end

    always_comb begin
        full_rows = '0;
        for (int i = 0; i < ROWS; i++) begin
            full_rows[i] = &board_q[i];
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the board is a flop array, not a RAM macro, so it can and
            // must be cleared by reset; a new game starts from an empty board.
            for (int i = 0; i < ROWS; i++) begin
                board_q[i] <= '0;
            end
            game_over_q <= GO_RUN;
            lines_q     <= '0;
            rd_data_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values computed by the combinational blocks.
            board_q     <= board_d;
            game_over_q <= game_over_d;
            lines_q     <= lines_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign game_over     = game_over_q;
    assign lines_cleared = lines_q;
    assign rd_data       = rd_data_q;

endmodule

// File: tb/tb_playfield_store.sv
// -----------------------------------------------------------------------------
// tb_playfield_store
//   Directed stimulus for playfield_store. Each stimulus cycle pushes the
//   hand-computed outputs expected after the next clock edge into a scoreboard
//   queue; an independent monitor samples on the falling edge and compares.
// -----------------------------------------------------------------------------
module tb_playfield_store;

    localparam int ROWS = 22;
    localparam int COLS = 10;
    localparam int LW   = 16;

    localparam logic [2:0] C_CHK = 3'b000;
    localparam logic [2:0] C_WR  = 3'b010;
    localparam logic [2:0] C_SH  = 3'b011;
    localparam logic [2:0] C_ADD = 3'b100;
    localparam logic [2:0] C_LR  = 3'b111;

    logic            clk = 1'b0;
    logic            reset;
    logic [2:0]      cmd;
    logic [ROWS-1:0] shift_row;
    logic [15:0]     piece_mask;
    logic [4:0]      piece_x;
    logic [4:0]      piece_y;
    logic [ROWS-1:0] full_rows;
    logic [1:0]      game_over;
    logic [LW-1:0]   lines_cleared;
    logic [4:0]      rd_row;
    logic [COLS-1:0] rd_data;

    playfield_store #(.ROWS(ROWS), .COLS(COLS), .LINES_W(LW)) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd           (cmd),
        .shift_row     (shift_row),
        .piece_mask    (piece_mask),
        .piece_x       (piece_x),
        .piece_y       (piece_y),
        .full_rows     (full_rows),
        .game_over     (game_over),
        .lines_cleared (lines_cleared),
        .rd_row        (rd_row),
        .rd_data       (rd_data)
    );

    always #5 clk = ~clk;

    typedef enum int {F_FULL, F_GO, F_LINES, F_RD} field_e;

    typedef struct {
        int          due;
        field_e      field;
        string       name;
        logic [31:0] value;
    } exp_t;

    exp_t sb[$];
    int   neg_cnt  = 0;
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string n, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
        end
    endtask

    // Monitor: every falling edge, compare all expectations due at this sample.
    initial begin
        forever begin
            @(negedge clk);
            neg_cnt++;
            while (sb.size() > 0 && sb[0].due <= neg_cnt) begin
                exp_t        e;
                logic [31:0] act;
                e = sb.pop_front();
                case (e.field)
                    F_FULL:  act = 32'(full_rows);
                    F_GO:    act = 32'(game_over);
                    F_LINES: act = 32'(lines_cleared);
                    default: act = 32'(rd_data);
                endcase
                if (e.due != neg_cnt) begin
                    failures++;
                    $display("FAIL %s: sampled late (sample %0d, due %0d)",
                             e.name, neg_cnt, e.due);
                end
                check(e.name, act, e.value);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, pending=%0d expected 0",
                 sb.size());
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] c, input logic [15:0] m,
                         input logic [4:0] x, input logic [4:0] y,
                         input logic [ROWS-1:0] sh, input logic [4:0] rr);
        cmd        = c;
        piece_mask = m;
        piece_x    = x;
        piece_y    = y;
        shift_row  = sh;
        rd_row     = rr;
    endtask

    task automatic idle(input logic [4:0] rr);
        drive(C_CHK, 16'h0000, 5'd0, 5'd0, '0, rr);
    endtask

    // Inputs driven now take effect at the next edge, seen two samples ahead.
    task automatic sb_push(input field_e f, input string n, input logic [31:0] v);
        exp_t e;
        e.due   = neg_cnt + 2;
        e.field = f;
        e.name  = n;
        e.value = v;
        sb.push_back(e);
    endtask

    initial begin
        reset = 1'b1;
        idle(5'd0);
        tick();
        tick();

        // Reset state
        sb_push(F_FULL,  "rst_full",  32'h0);
        sb_push(F_GO,    "rst_go",    32'h0);
        sb_push(F_LINES, "rst_lines", 32'h0);
        sb_push(F_RD,    "rst_rd",    32'h0);
        tick();
        reset = 1'b0;

        // Test 1: write a 4-wide bar into the bottom row
        drive(C_WR, 16'h000F, 5'd0, 5'd21, '0, 5'd21);
        sb_push(F_FULL, "t1_full",    32'h0);
        sb_push(F_GO,   "t1_go",      32'h0);
        sb_push(F_RD,   "t1_rd_old",  32'h0);
        tick();
        check("t1_go_direct", 32'(game_over), 32'h0);
        idle(5'd21);
        sb_push(F_RD, "t1_row21", 32'h00F);
        tick();

        // Marker in row 20 so the shift result is visible
        drive(C_WR, 16'h0001, 5'd2, 5'd20, '0, 5'd0);
        sb_push(F_GO, "t2_mark_go", 32'h0);
        tick();
        idle(5'd20);
        sb_push(F_RD, "t2_row20_mark", 32'h004);
        tick();

        // Test 2: complete row 21 then delete it
        drive(C_WR, 16'h000F, 5'd4, 5'd21, '0, 5'd0);
        sb_push(F_FULL, "t2_full_partial", 32'h0);
        tick();
        drive(C_WR, 16'h0003, 5'd8, 5'd21, '0, 5'd0);
        sb_push(F_FULL, "t2_full_row21", 32'h200000);
        sb_push(F_GO,   "t2_go",         32'h0);
        tick();
        drive(C_SH, 16'h0000, 5'd0, 5'd0, 22'h200000, 5'd21);
        sb_push(F_LINES, "t2_lines",        32'h1);
        sb_push(F_FULL,  "t2_full_after",   32'h0);
        sb_push(F_RD,    "t2_rd_old_shift", 32'h3FF);
        tick();
        check("t2_lines_direct", 32'(lines_cleared), 32'h1);
        idle(5'd21);
        sb_push(F_RD, "t2_row21_from20", 32'h004);
        tick();
        idle(5'd20);
        sb_push(F_RD, "t2_row20_from19", 32'h000);
        tick();

        // lr command must leave the board alone
        drive(C_LR, 16'hFFFF, 5'd0, 5'd0, '0, 5'd21);
        sb_push(F_RD,   "lr_row21", 32'h004);
        sb_push(F_FULL, "lr_full",  32'h0);
        tick();
        idle(5'd0);
        sb_push(F_RD, "lr_row0_clean", 32'h000);
        tick();

        // Test 3: rows 20 and 21 full, delete bottom one at a time
        drive(C_WR, 16'h000F, 5'd0, 5'd20, '0, 5'd0); tick();
        drive(C_WR, 16'h000F, 5'd4, 5'd20, '0, 5'd0); tick();
        drive(C_WR, 16'h0003, 5'd0, 5'd21, '0, 5'd0); tick();
        drive(C_WR, 16'h000F, 5'd3, 5'd21, '0, 5'd0); tick();
        drive(C_WR, 16'h0001, 5'd7, 5'd21, '0, 5'd0); tick();
        drive(C_WR, 16'h0033, 5'd8, 5'd20, '0, 5'd0);
        sb_push(F_FULL, "t3_full_two", 32'h300000);
        sb_push(F_GO,   "t3_go",       32'h0);
        tick();
        drive(C_SH, 16'h0000, 5'd0, 5'd0, 22'h300000, 5'd20);
        sb_push(F_FULL,  "t3_full_one", 32'h200000);
        sb_push(F_LINES, "t3_lines_a",  32'h2);
        sb_push(F_RD,    "t3_rd_row20", 32'h3FF);
        tick();
        drive(C_SH, 16'h0000, 5'd0, 5'd0, 22'h200000, 5'd21);
        sb_push(F_FULL,  "t3_full_none", 32'h0);
        sb_push(F_LINES, "t3_lines_b",   32'h3);
        sb_push(F_RD,    "t3_rd_row21",  32'h3FF);
        tick();
        idle(5'd21);
        sb_push(F_RD, "t3_row21_empty", 32'h0);
        tick();
        idle(5'd20);
        sb_push(F_RD, "t3_row20_empty", 32'h0);
        tick();
        drive(C_SH, 16'h0000, 5'd0, 5'd0, '0, 5'd0);
        sb_push(F_LINES, "t3_shift_zero", 32'h3);
        tick();

        // Test 4: right-edge clipping, then overlap write sets sticky 01
        drive(C_WR, 16'h000F, 5'd8, 5'd0, '0, 5'd0);
        sb_push(F_GO,   "t4_clip_go",   32'h0);
        sb_push(F_FULL, "t4_clip_full", 32'h0);
        tick();
        idle(5'd0);
        sb_push(F_RD, "t4_row0_clip", 32'h300);
        tick();
        drive(C_WR, 16'h000F, 5'd8, 5'd0, '0, 5'd0);
        sb_push(F_GO, "t4_overlap", 32'h1);
        tick();
        drive(C_ADD, 16'h0003, 5'd8, 5'd0, '0, 5'd0);
        sb_push(F_GO, "t4_sticky_add", 32'h1);
        tick();
        drive(C_SH, 16'h0000, 5'd0, 5'd0, 22'h000001, 5'd0);
        sb_push(F_LINES, "t4_shift_row0", 32'h4);
        sb_push(F_GO,    "t4_sticky_sh",  32'h1);
        sb_push(F_RD,    "t4_rd_old",     32'h300);
        tick();
        idle(5'd0);
        sb_push(F_RD, "t4_row0_cleared", 32'h0);
        sb_push(F_GO, "t4_sticky_chk",   32'h1);
        tick();
        reset = 1'b1;
        idle(5'd0);
        sb_push(F_GO,    "t4_reset_go",    32'h0);
        sb_push(F_LINES, "t4_reset_lines", 32'h0);
        tick();
        check("t4_reset_go_direct",    32'(game_over),     32'h0);
        check("t4_reset_lines_direct", 32'(lines_cleared), 32'h0);
        reset = 1'b0;

        // Test 5: spawn check
        drive(C_WR, 16'h0001, 5'd4, 5'd0, '0, 5'd0);
        sb_push(F_GO, "t5_write_go", 32'h0);
        tick();
        drive(C_ADD, 16'h0001, 5'd5, 5'd0, '0, 5'd0);
        sb_push(F_GO, "t5_add_clear", 32'h0);
        tick();
        drive(C_ADD, 16'hFFFF, 5'd8, 5'd21, '0, 5'd0);
        sb_push(F_GO, "t5_add_clipped", 32'h0);
        tick();
        drive(C_ADD, 16'h0001, 5'd4, 5'd0, '0, 5'd0);
        sb_push(F_GO, "t5_blocked", 32'h2);
        tick();
        drive(C_ADD, 16'h0001, 5'd4, 5'd0, '0, 5'd0);
        sb_push(F_GO, "t5_blocked_again", 32'h2);
        tick();
        idle(5'd0);
        sb_push(F_RD, "t5_board_same", 32'h010);
        tick();
        drive(C_WR, 16'h0001, 5'd4, 5'd0, '0, 5'd0);
        sb_push(F_GO, "t5_code_held", 32'h2);
        tick();

        // Test 6: read port range, bottom clipping, reset during write
        idle(5'd25);
        sb_push(F_RD, "t6_rd_oor", 32'h0);
        tick();
        drive(C_WR, 16'hFFFF, 5'd8, 5'd21, '0, 5'd0);
        sb_push(F_GO, "t6_clip_go", 32'h2);
        tick();
        idle(5'd21);
        sb_push(F_RD, "t6_row21_clip", 32'h300);
        tick();
        reset = 1'b1;
        drive(C_WR, 16'h000F, 5'd0, 5'd21, '0, 5'd21);
        sb_push(F_GO,    "t6_rst_go",    32'h0);
        sb_push(F_LINES, "t6_rst_lines", 32'h0);
        sb_push(F_RD,    "t6_rst_rd",    32'h0);
        sb_push(F_FULL,  "t6_rst_full",  32'h0);
        tick();
        reset = 1'b0;
        idle(5'd21);
        sb_push(F_RD, "t6_row21_empty", 32'h0);
        tick();
        idle(5'd0);
        sb_push(F_RD, "t6_row0_empty", 32'h0);
        tick();

        repeat (4) tick();
        check("end_full",  32'(full_rows),     32'h0);
        check("end_go",    32'(game_over),     32'h0);
        check("end_lines", 32'(lines_cleared), 32'h0);
        check("end_rd",    32'(rd_data),       32'h0);
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            failures++;
            $display("FAIL %s: never sampled, expected 0x%0h", e.name, e.value);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
